// File: rtl/prop_chain_checker_if.sv
// Handshake bundle for prop_chain_checker: source value in, per-chain verdict out.
// master drives the stimulus and accepts results; slave is the checker itself.
interface prop_chain_checker_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [3:0]       in_inj;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_flags;
  logic             out_match;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    output in_valid, in_data, in_inj, out_ready,
    input  in_ready, out_valid, out_flags, out_match, out_data, err_count, busy
  );

  modport slave (
    input  in_valid, in_data, in_inj, out_ready,
    output in_ready, out_valid, out_flags, out_match, out_data, err_count, busy
  );
endinterface

// File: rtl/prop_chain_checker.sv
// Purpose: drive four two-deep combinational chains from a registered source and check them.
// Latency: result valid 2 cycles after the accept edge; one transaction in flight at a time.
// Backpressure: REPORT holds all outputs until out_ready; in_ready stays low until then.
module prop_chain_checker #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  prop_chain_checker_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0]       state_q;
  logic [W-1:0]     a_q;
  logic [3:0]       inj_q;
  logic [3:0]       flags_q;
  logic             match_q;
  logic [W-1:0]     data_q;
  logic [CNT_W-1:0] err_q;

  // Chain nodes; b2/b4/b6/b8 carry the optional bit-0 fault.
  logic [W-1:0] b1, b2, b3, b4, b5, b6, b7, b8;
  logic [W-1:0] exp_lg, exp_add;
  logic [3:0]   flags_c;

  assign b1 = a_q;
  assign b2 = b1 ^ {{(W-1){1'b0}}, inj_q[0]};
  assign b3 = {{(W-1){1'b0}}, ~|a_q};
  assign b4 = {{(W-1){1'b0}}, ~|b3} ^ {{(W-1){1'b0}}, inj_q[1]};
  assign b5 = ~a_q;
  assign b6 = ~b5 ^ {{(W-1){1'b0}}, inj_q[2]};
  assign b7 = a_q + W'(1);
  assign b8 = (b7 + W'(1)) ^ {{(W-1){1'b0}}, inj_q[3]};

  assign exp_lg  = {{(W-1){1'b0}}, |a_q};
  assign exp_add = a_q + W'(2);

  assign flags_c = {b8 == exp_add, b6 == a_q, b4 == exp_lg, b2 == a_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      inj_q   <= '0;
      flags_q <= '0;
      match_q <= 1'b0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_data;
            inj_q   <= bus.in_inj;
            state_q <= S_DRIVE;
          end
        end
        S_DRIVE: state_q <= S_SAMPLE;
        S_SAMPLE: begin
          flags_q <= flags_c;
          match_q <= &flags_c;
          data_q  <= b8;
          state_q <= S_REPORT;
        end
        default: begin
          if (bus.out_ready) begin
            if (!match_q && (err_q != {CNT_W{1'b1}})) err_q <= err_q + CNT_W'(1);
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_REPORT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_flags = flags_q;
  assign bus.out_match = match_q;
  assign bus.out_data  = data_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_prop_chain_checker.sv
// Bench for prop_chain_checker: directed vectors, corner sequences and random traffic
// against an arithmetic reference; a second instance with a 2-bit counter shares the stimulus.
module tb_prop_chain_checker;

  logic clk;
  logic rst;

  prop_chain_checker_if #(.W(8), .CNT_W(16)) bm ();
  prop_chain_checker_if #(.W(8), .CNT_W(2))  bs ();

  assign bs.in_valid  = bm.in_valid;
  assign bs.in_data   = bm.in_data;
  assign bs.in_inj    = bm.in_inj;
  assign bs.out_ready = bm.out_ready;

  prop_chain_checker #(.W(8), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bm));
  prop_chain_checker #(.W(8), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int err_m   = 0;
  int err_s   = 0;

  typedef struct {
    logic [7:0] a;
    logic [3:0] inj;
    logic [3:0] f;
    logic       m;
    logic [7:0] d;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: build each faulted final node from the chain's arithmetic meaning.
  function automatic void model(input int a, input int inj,
                                output logic [3:0] f, output logic m, output logic [7:0] d);
    int n_id, n_lg, n_bw, n_ad, e_lg, e_ad;
    e_lg = (a != 0) ? 1 : 0;
    e_ad = (a + 2) % 256;
    n_id = a    ^ (inj & 1);
    n_lg = e_lg ^ ((inj >> 1) & 1);
    n_bw = a    ^ ((inj >> 2) & 1);
    n_ad = e_ad ^ ((inj >> 3) & 1);
    f = {n_ad == e_ad, n_bw == a, n_lg == e_lg, n_id == a};
    m = (f == 4'hF);
    d = n_ad[7:0];
  endfunction

  task automatic txn(input logic [7:0] a, input logic [3:0] inj, input int stall, input bit pulse,
                     output logic [3:0] gf, output logic gm, output logic [7:0] gd);
    logic [3:0] ef;
    logic       em;
    logic [7:0] ed;
    int         lat;
    model(a, inj, ef, em, ed);
    chk("in_ready_before_accept", bm.in_ready, 1);
    bm.in_valid = 1'b1;
    bm.in_data  = a;
    bm.in_inj   = inj;
    @(posedge clk);
    @(negedge clk);
    bm.in_valid = 1'b0;
    chk("busy_after_accept", bm.busy, 1);
    lat = 0;
    while (!bm.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    gf = bm.out_flags;
    gm = bm.out_match;
    gd = bm.out_data;
    chk("flags", gf, ef);
    chk("match", gm, em);
    chk("data", gd, ed);
    chk("flags_small", bs.out_flags, ef);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_out_valid", bm.out_valid, 1);
      chk("stall_in_ready", bm.in_ready, 0);
      chk("stall_flags", bm.out_flags, ef);
      chk("stall_data", bm.out_data, ed);
      chk("stall_err", bm.err_count, err_m);
      if (pulse) begin
        bm.in_valid = ~i[0];
        bm.in_data  = 8'(i * 37);
      end
    end
    bm.in_valid  = 1'b0;
    bm.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bm.out_ready = 1'b0;
    if (!em) begin
      if (err_m != 65535) err_m++;
      if (err_s != 3) err_s++;
    end
    chk("err_count", bm.err_count, err_m);
    chk("err_count_small", bs.err_count, err_s);
    chk("idle_after_handshake", bm.in_ready, 1);
    chk("out_valid_dropped", bm.out_valid, 0);
    chk("flags_held", bm.out_flags, ef);
    chk("data_held", bm.out_data, ed);
  endtask

  initial begin
    logic [3:0] gf;
    logic       gm;
    logic [7:0] gd;
    bit         seen;
    int         exp_sat [4];

    vt[0] = '{8'h01, 4'b0000, 4'b1111, 1'b1, 8'h03};
    vt[1] = '{8'hFF, 4'b0000, 4'b1111, 1'b1, 8'h01};
    vt[2] = '{8'h00, 4'b0000, 4'b1111, 1'b1, 8'h02};
    vt[3] = '{8'h00, 4'b0010, 4'b1101, 1'b0, 8'h02};
    vt[4] = '{8'h7F, 4'b1000, 4'b0111, 1'b0, 8'h80};
    exp_sat = '{1, 2, 3, 3};

    rst          = 1'b1;
    bm.in_valid  = 1'b0;
    bm.in_data   = '0;
    bm.in_inj    = '0;
    bm.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bm.in_ready, 1);
    chk("rst_out_valid", bm.out_valid, 0);
    chk("rst_flags", bm.out_flags, 0);
    chk("rst_match", bm.out_match, 0);
    chk("rst_data", bm.out_data, 0);
    chk("rst_err", bm.err_count, 0);
    chk("rst_busy", bm.busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      txn(vt[i].a, vt[i].inj, 0, 1'b0, gf, gm, gd);
      chk("vec_flags", gf, vt[i].f);
      chk("vec_match", gm, vt[i].m);
      chk("vec_data", gd, vt[i].d);
    end
    chk("vec_err_total", bm.err_count, 2);

    // Backpressure with in_valid toggling while REPORT is stalled.
    txn(8'h33, 4'b0100, 5, 1'b1, gf, gm, gd);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bm.busy) seen = 1'b1;
    end
    chk("no_extra_txn", seen, 0);

    // Reset while in DRIVE drops the transaction.
    bm.in_valid = 1'b1;
    bm.in_data  = 8'h05;
    bm.in_inj   = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    bm.in_valid = 1'b0;
    chk("drive_busy", bm.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    err_m = 0;
    err_s = 0;
    chk("midrst_out_valid", bm.out_valid, 0);
    chk("midrst_in_ready", bm.in_ready, 1);
    chk("midrst_busy", bm.busy, 0);
    chk("midrst_err", bm.err_count, 0);
    chk("midrst_flags", bm.out_flags, 0);
    chk("midrst_data", bm.out_data, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bm.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);

    // Reset and in_valid together: nothing captured.
    rst         = 1'b1;
    bm.in_valid = 1'b1;
    bm.in_data  = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    bm.in_valid = 1'b0;
    chk("rst_wins_busy", bm.busy, 0);
    chk("rst_wins_in_ready", bm.in_ready, 1);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      txn(8'($urandom_range(0, 255)), 4'b0001, 0, 1'b0, gf, gm, gd);
      chk("sat_seq", bs.err_count, exp_sat[i]);
    end
    chk("sat_main_err", bm.err_count, 4);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [3:0] ri;
      ra = 8'($urandom_range(0, 255));
      if (i % 8 == 0) ra = 8'hFF;
      if (i % 8 == 1) ra = 8'h00;
      ri = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
      txn(ra, ri, int'($urandom_range(0, 3)), 1'b0, gf, gm, gd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prop_chain_checker.md
# prop_chain_checker

Self-checking stimulus/response stage for continuous-assignment propagation chains. Accepts a value over a valid/ready handshake and registers it as the chain source. Drives four two-deep combinational chains from that register: identity, double logical-not, double bitwise-not, and +1+1. Captures the settled chain outputs, compares each against its expected value, and reports per-chain match flags downstream. Keeps a saturating mismatch count.

## Interface
- `W`, 8: data width of source and all W-bit chain nodes.
- `CNT_W`, 16: width of the mismatch counter.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: source value offered.
- `in_ready` out 1: high only in IDLE.
- `in_data` in W: source value `a`.
- `in_inj` in 4: fault-injection mask, captured with `in_data`. Bit i inverts bit 0 of chain i's final node.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts result.
- `out_flags` out 4: per-chain match; bit0 identity, bit1 logical, bit2 bitwise, bit3 add.
- `out_match` out 1: AND of `out_flags`.
- `out_data` out W: captured final node of add chain (`b8`).
- `err_count` out CNT_W: saturating count of delivered results with `out_match`=0.
- `busy` out 1: state != IDLE.

## Operation
- Chains are pure continuous assignments fed from the source register `a_q`:
  - b1=a_q, b2=b1
  - b3=!a_q (1-bit, zero-extended to W), b4=!b3
  - b5=~a_q, b6=~b5
  - b7=a_q+1, b8=b7+1, both truncated to W
- Fault injection is applied on b2/b4/b6/b8 only.
- Expected values:
  - b2==a_q
  - b4=={{W-1{0}},(a_q!=0)}
  - b6==a_q
  - b8==(a_q+2) mod 2^W; wraps, e.g. a=FF gives 01 at W=8.
- FSM states: IDLE, DRIVE, SAMPLE, REPORT.
  - IDLE: in_ready=1. On in_valid, capture `a_q`←`in_data` and `inj_q`←`in_inj`, then go to DRIVE.
  - DRIVE: settle cycle. Nothing is captured. Go to SAMPLE.
  - SAMPLE: register `out_flags`, `out_match`, `out_data` from the chain nodes. Go to REPORT.
  - REPORT: out_valid=1.
    - When out_ready=1: if `out_match`=0, increment `err_count`, holding at 2^CNT_W−1. Then go to IDLE.
    - Otherwise hold state.
- `out_flags`, `out_match` and `out_data` hold their last captured values after the handshake. They change only at the next SAMPLE.
- in_valid outside IDLE is ignored; no buffering.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_flags=0, out_match=0, out_data=0, err_count=0, busy=0, a_q=0, inj_q=0.
- Accept at edge k.
  - busy=1 from edge k.
  - DRIVE during cycle k..k+1.
  - Capture at edge k+2; out_valid=1 from edge k+2.
- Latency: result is visible 2 cycles after the accept edge.
- Minimum period is 4 cycles per transaction: accept, DRIVE, SAMPLE, REPORT with out_ready=1, then IDLE one cycle before the next accept.
- Backpressure: while out_valid=1 and out_ready=0, all out_* outputs, err_count and in_ready=0 stay stable.
- err_count updates on the same edge as the REPORT handshake.
- Reset mid-operation, at any state, takes effect on that edge:
  - returns to IDLE and clears all outputs and err_count;
  - the in-flight transaction is dropped, with no result and no count.
- in_valid and rst in the same cycle: reset wins and nothing is captured.

## Test plan
- Basic: rst, then in_data=01, inj=0 → out_valid at accept+2, flags=1111, match=1, out_data=03, err_count=0.
- Wrap: in_data=FF → out_data=01, flags=1111. Then in_data=00 → out_data=02, flags=1111 (logical chain yields 0).
- Fault: in_data=00, inj=0010 → flags=1101, match=0. err_count 0→1 on handshake. A following inj=1000 with a=7F → out_data=80, flags=0111, err_count=2.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 pulsing → outputs stable, in_ready=0, no extra transaction. Release → err_count update and IDLE next edge.
- Reset mid-op: accept a=05, assert rst in DRIVE → next edge out_valid=0, in_ready=1, busy=0, err_count=0, and no result is ever emitted.
- Saturation: CNT_W=2, four transactions with inj=0001 → err_count sequence 1, 2, 3, 3.
